// File: rtl/ecc_pkg.sv
// ecc_pkg: shared ECC(38,32) constants, column codes and check-bit function
// ECC_DW/ECC_CW: data/check widths; ECC_INV: check-bit inversion constant
// ECC_H[k]: syndrome column for data bit k; ecc_chk(d): encoder check bits
package ecc_pkg;
    localparam int ECC_DW = 32;
    localparam int ECC_CW = 6;
    localparam logic [ECC_CW-1:0] ECC_INV = 6'b010101;
    localparam logic [ECC_DW-1:0][ECC_CW-1:0] ECC_H = {
        6'b110000, 6'b101000, 6'b100100, 6'b100010, 6'b100001,
        6'b011000, 6'b010100, 6'b010010, 6'b010001,
        6'b001100, 6'b001010, 6'b001001,
        6'b000110, 6'b000101, 6'b000011,
        6'b110100, 6'b110010, 6'b110001, 6'b101100,
        6'b101001, 6'b100110, 6'b100101, 6'b100011,
        6'b011100, 6'b011010, 6'b011001, 6'b010110, 6'b010101,
        6'b010011, 6'b001110, 6'b001101, 6'b001011
    };

    function automatic logic [ECC_CW-1:0] ecc_chk(input logic [ECC_DW-1:0] d);
        logic [ECC_CW-1:0] c;
        c = '0;
        for (int k = 0; k < ECC_DW; k++) c ^= {ECC_CW{d[k]}} & ECC_H[k];
        return c ^ ECC_INV;
    endfunction
endpackage

// File: rtl/ecc_syn_corr.sv
// ecc_syn_corr: combinational syndrome decode and single-bit correction
// syn_i: syndrome, data_i: raw data; data_o: corrected data (raw on UE)
// sbe_o: single data/check bit error corrected, ue_o: uncorrectable
module ecc_syn_corr
    import ecc_pkg::*;
(
    input  logic [ECC_CW-1:0] syn_i,
    input  logic [ECC_DW-1:0] data_i,
    output logic [ECC_DW-1:0] data_o,
    output logic              sbe_o,
    output logic              ue_o
);
    logic [ECC_DW-1:0] flip;
    logic              chk_err;

    always_comb begin
        flip = '0;
        for (int k = 0; k < ECC_DW; k++) flip[k] = (syn_i == ECC_H[k]);
    end

    // a one-hot syndrome points at a check bit, so data needs no fix
    assign chk_err = (syn_i != '0) && ((syn_i & (syn_i - 6'd1)) == '0);
    assign data_o  = data_i ^ flip;
    assign sbe_o   = (|flip) | chk_err;
    assign ue_o    = (syn_i != '0) & ~sbe_o;
endmodule

// File: rtl/ecc_dec_module.sv
// ecc_dec_module: 2-stage pipelined ECC(38,32) decoder/corrector with stats
// in_valid/in_ready/in_code: codeword input ([37:32] check, [31:0] data)
// out_valid/out_ready/out_data/out_sbe/out_ue/out_syn: decoded result
// cnt_clr: clears counters and log; sbe_cnt/ue_cnt: saturating counts
// log_vld/log_syn: sticky syndrome of first erroneous word since clear
module ecc_dec_module
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [37:0]         in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ECC_DW-1:0]   out_data,
    output logic                out_sbe,
    output logic                out_ue,
    output logic [ECC_CW-1:0]   out_syn,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    sbe_cnt,
    output logic [CNT_W-1:0]    ue_cnt,
    output logic                log_vld,
    output logic [ECC_CW-1:0]   log_syn
);
    logic              s1_vld_q, out_valid_q, out_sbe_q, out_ue_q, log_vld_q, log_vld_d;
    logic [37:0]       s1_code_q;
    logic [ECC_CW-1:0] s1_syn_q, out_syn_q, log_syn_q, log_syn_d;
    logic [ECC_DW-1:0] out_data_q, corr_data;
    logic              corr_sbe, corr_ue, en1, en2, xfer;
    logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d, ue_cnt_q, ue_cnt_d;

    assign en2      = ~out_valid_q | out_ready;
    assign en1      = ~s1_vld_q | en2;
    assign in_ready = en1;
    assign xfer     = out_valid_q & out_ready;

    ecc_syn_corr u_corr (
        .syn_i  (s1_syn_q),
        .data_i (s1_code_q[ECC_DW-1:0]),
        .data_o (corr_data),
        .sbe_o  (corr_sbe),
        .ue_o   (corr_ue)
    );

    always_comb begin
        sbe_cnt_d = cnt_clr ? '0 : (xfer & out_sbe_q & ~&sbe_cnt_q) ? sbe_cnt_q + CNT_W'(1) : sbe_cnt_q;
        ue_cnt_d  = cnt_clr ? '0 : (xfer & out_ue_q & ~&ue_cnt_q) ? ue_cnt_q + CNT_W'(1) : ue_cnt_q;
        log_vld_d = cnt_clr ? 1'b0 : log_vld_q | (xfer & (out_sbe_q | out_ue_q));
        log_syn_d = cnt_clr ? '0 : (xfer & (out_sbe_q | out_ue_q) & ~log_vld_q) ? out_syn_q : log_syn_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sbe_q   <= 1'b0;
            out_ue_q    <= 1'b0;
            out_syn_q   <= '0;
            sbe_cnt_q   <= '0;
            ue_cnt_q    <= '0;
            log_vld_q   <= 1'b0;
            log_syn_q   <= '0;
        end else begin
            if (en1) begin
                s1_vld_q  <= in_valid;
                s1_code_q <= in_code;
                s1_syn_q  <= in_code[37:32] ^ ecc_chk(in_code[ECC_DW-1:0]);
            end
            if (en2) begin
                out_valid_q <= s1_vld_q;
                out_data_q  <= corr_data;
                out_sbe_q   <= corr_sbe;
                out_ue_q    <= corr_ue;
                out_syn_q   <= s1_syn_q;
            end
            sbe_cnt_q <= sbe_cnt_d;
            ue_cnt_q  <= ue_cnt_d;
            log_vld_q <= log_vld_d;
            log_syn_q <= log_syn_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sbe   = out_sbe_q;
    assign out_ue    = out_ue_q;
    assign out_syn   = out_syn_q;
    assign sbe_cnt   = sbe_cnt_q;
    assign ue_cnt    = ue_cnt_q;
    assign log_vld   = log_vld_q;
    assign log_syn   = log_syn_q;
endmodule
